// File: rtl/sram_responder_if.sv
// Control pins of the 16-bit asynchronous-SRAM style interface driven by the
// Mips core. The bidirectional data bus is carried as a separate inout port.
interface sram_responder_if #(
  parameter int ADDR_W = 18
);
  logic [ADDR_W-1:0] addr;
  logic              wre;      // write enable, active-low
  logic              oute;     // output enable, active-low
  logic              hb_mask;  // high byte lane select, active-low
  logic              lb_mask;  // low byte lane select, active-low
  logic              chip_en;  // chip select, active-low

  modport master (output addr, wre, oute, hb_mask, lb_mask, chip_en);
  modport slave  (input  addr, wre, oute, hb_mask, lb_mask, chip_en);
endinterface

// File: rtl/sram_responder.sv
// Clocked SRAM responder: samples the SRAM pins on every rising edge, backs
// them with a word array, returns read data after READ_LAT cycles, commits
// byte-lane writes when the write strobe ends, and keeps saturating access
// counters plus a sticky out-of-range flag.
module sram_responder #(
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 16,   // two byte lanes; the lane logic assumes 16
  parameter int DEPTH    = 4096, // words implemented; addr wraps modulo DEPTH
  parameter int READ_LAT = 1     // sample-to-drive latency, legal 1..4
) (
  input  logic               clock,
  input  logic               reset,
  sram_responder_if.slave    bus,
  inout  wire  [DATA_W-1:0]  data,
  output logic [15:0]        rd_count,
  output logic [15:0]        wr_count,
  output logic               oor
);

  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
  localparam logic [1:0]        LAT_LOAD = 2'(READ_LAT - 1);
  localparam logic [15:0]       CNT_MAX  = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_ARM  = 2'd1,
    READ_WAIT  = 2'd2,
    READ_DRIVE = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  // Decoded pin requests, all taken from the live pins at the sampling edge.
  logic sel;
  logic wr_req;
  logic rd_req;
  logic addr_moved;
  logic addr_oor;

  // Control strobes produced by the output process.
  logic wr_latch;
  logic wr_commit;
  logic rd_capture;
  logic rd_load;
  logic lat_dec;

  // Armed write, captured read address and latency countdown.
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              wr_hb_q;
  logic              wr_lb_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [1:0]        lat_cnt;
  logic [15:0]       rd_count_q;
  logic [15:0]       wr_count_q;
  logic              oor_q;

  // Storage and the registered read word presented in READ_DRIVE.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              wr_oor;

  // Bus drive enables, gated combinationally by the live pins.
  logic       drive_en;
  logic [1:0] lane_oe;

  assign sel        = !bus.chip_en && (!bus.hb_mask || !bus.lb_mask);
  assign wr_req     = sel && !bus.wre;
  assign rd_req     = sel && bus.wre && !bus.oute;
  assign addr_moved = (bus.addr != rd_addr_q);
  assign addr_oor   = (bus.addr >= DEPTH_A);
  assign wr_oor     = (wr_addr_q >= DEPTH_A);

  assign wr_idx = IDX_W'(wr_addr_q % DEPTH_A);
  assign rd_idx = IDX_W'(rd_addr_q % DEPTH_A);

  // State register; reset abandons any armed write by returning to IDLE.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block evaluation order.
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state decode; a write request always wins over a read request.
  always_comb begin
    // NOTE: the default assignment comes first so every path assigns
    // next_state and no latch can be inferred.
    next_state = state;
    unique case (state)
      IDLE: begin
        if (wr_req)      next_state = WRITE_ARM;
        else if (rd_req) next_state = READ_WAIT;
      end
      WRITE_ARM: begin
        if (!wr_req) next_state = IDLE;
      end
      READ_WAIT: begin
        if (lat_cnt == 2'd0) next_state = READ_DRIVE;
      end
      READ_DRIVE: begin
        if (wr_req)                    next_state = WRITE_ARM;
        else if (rd_req && addr_moved) next_state = READ_WAIT;
        else if (!rd_req)              next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Per-state control strobes for the datapath and memory.
  always_comb begin
    wr_latch   = 1'b0;
    wr_commit  = 1'b0;
    rd_capture = 1'b0;
    rd_load    = 1'b0;
    lat_dec    = 1'b0;
    unique case (state)
      IDLE: begin
        wr_latch   = wr_req;
        rd_capture = rd_req;
      end
      WRITE_ARM: begin
        wr_latch  = wr_req;
        wr_commit = !wr_req;
      end
      READ_WAIT: begin
        rd_load = (lat_cnt == 2'd0);
        lat_dec = (lat_cnt != 2'd0);
      end
      READ_DRIVE: begin
        wr_latch   = wr_req;
        rd_capture = rd_req && addr_moved;
      end
      default: ;
    endcase
  end

  // Write latch, read capture, latency countdown, counters and sticky flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_hb_q    <= 1'b1;
      wr_lb_q    <= 1'b1;
      rd_addr_q  <= '0;
      lat_cnt    <= 2'd0;
      rd_count_q <= 16'd0;
      wr_count_q <= 16'd0;
      oor_q      <= 1'b0;
    end else begin
      if (wr_latch) begin
        wr_addr_q <= bus.addr;
        wr_data_q <= data;
        wr_hb_q   <= bus.hb_mask;
        wr_lb_q   <= bus.lb_mask;
      end

      if (rd_capture) begin
        rd_addr_q <= bus.addr;
        lat_cnt   <= LAT_LOAD;
      end else if (lat_dec) begin
        lat_cnt <= lat_cnt - 2'd1;
      end

      if (rd_load && (rd_count_q != CNT_MAX)) rd_count_q <= rd_count_q + 16'd1;
      if (wr_commit && (wr_count_q != CNT_MAX)) wr_count_q <= wr_count_q + 16'd1;

      if ((rd_capture && addr_oor) || (wr_commit && wr_oor)) oor_q <= 1'b1;
    end
  end

  // Lane-masked write commit and read word registration on entry to READ_DRIVE.
  // NOTE: the array and read register have no reset: contents survive reset
  // and the storage can map onto block RAM.
  always_ff @(posedge clock) begin
    if (wr_commit) begin
      if (!wr_hb_q) mem[wr_idx][15:8] <= wr_data_q[15:8];
      if (!wr_lb_q) mem[wr_idx][7:0]  <= wr_data_q[7:0];
    end
    if (rd_load) rd_word <= mem[rd_idx];
  end

  // The bus is released the moment any qualifying pin deasserts or reset rises.
  assign drive_en   = (state == READ_DRIVE) && !reset &&
                      !bus.chip_en && !bus.oute && bus.wre;
  assign lane_oe[1] = drive_en && !bus.hb_mask;
  assign lane_oe[0] = drive_en && !bus.lb_mask;

  assign data[15:8] = lane_oe[1] ? rd_word[15:8] : 8'hzz;
  assign data[7:0]  = lane_oe[0] ? rd_word[7:0]  : 8'hzz;

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
  assign oor      = oor_q;

endmodule
